// File: rtl/sseg_capture.sv
// rtl/sseg_capture.sv - seven-segment bus monitor: decodes scanned glyphs back into a BCD frame
module sseg_capture #(
  parameter int TIMEOUT = 8,
  parameter bit STRICT  = 1'b1
) (
  input  logic        tic_ms,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  sseg,
  input  logic [3:0]  an,
  output logic [15:0] bcd_out,
  output logic        frame_valid,
  output logic        locked,
  output logic        pattern_err,
  output logic        anode_err,
  output logic        timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {OFF, ACQ, LOCK} state_t;

  state_t        state, state_n;
  logic [7:0]    sseg_q;
  logic [3:0]    an_q;
  logic [3:0]    seen, seen_n;
  logic          bad, bad_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   digits, digits_n;
  logic [15:0]   bcd_n;
  logic          fv_n, pe_n, ae_n, to_n;

  logic          glyph_ok;
  logic [3:0]    glyph_code;
  logic          slot_valid, slot_multi;
  logic [1:0]    slot_idx;
  logic [3:0]    seen_acc;
  logic          bad_acc;
  logic [15:0]   dig_acc;

  // dp is part of the match, so a lit decimal point makes the glyph undecodable
  always_comb begin
    glyph_ok   = 1'b1;
    glyph_code = 4'hF;
    case (sseg_q)
      8'hC0: glyph_code = 4'd0;
      8'hF9: glyph_code = 4'd1;
      8'hA4: glyph_code = 4'd2;
      8'hB0: glyph_code = 4'd3;
      8'h99: glyph_code = 4'd4;
      8'h92: glyph_code = 4'd5;
      8'h82: glyph_code = 4'd6;
      8'hF8: glyph_code = 4'd7;
      8'h80: glyph_code = 4'd8;
      8'h98: glyph_code = 4'd9;
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    slot_valid = 1'b0;
    slot_multi = 1'b0;
    slot_idx   = 2'd0;
    case (an_q)
      4'b1110: begin slot_valid = 1'b1; slot_idx = 2'd0; end
      4'b1101: begin slot_valid = 1'b1; slot_idx = 2'd1; end
      4'b1011: begin slot_valid = 1'b1; slot_idx = 2'd2; end
      4'b0111: begin slot_valid = 1'b1; slot_idx = 2'd3; end
      4'b1111: ;
      default: slot_multi = 1'b1;
    endcase
  end

  always_comb begin
    state_n  = state;
    seen_n   = seen;
    bad_n    = bad;
    cnt_n    = cnt;
    digits_n = digits;
    bcd_n    = bcd_out;
    fv_n     = 1'b0;
    pe_n     = 1'b0;
    ae_n     = 1'b0;
    to_n     = 1'b0;
    seen_acc = seen;
    bad_acc  = bad;
    dig_acc  = digits;
    if (!en) begin
      state_n = OFF;
      seen_n  = '0;
      bad_n   = 1'b0;
      cnt_n   = '0;
    end else if (state == OFF) begin
      state_n = ACQ;
    end else begin
      if (slot_valid) begin
        dig_acc[{slot_idx, 2'b00} +: 4] = glyph_code;
        seen_acc[slot_idx]              = 1'b1;
        if (!glyph_ok) begin
          bad_acc = 1'b1;
          pe_n    = 1'b1;
        end
      end
      ae_n     = slot_multi;
      digits_n = dig_acc;
      // completion is tested before timeout so a frame closing on the last cycle still counts
      if (seen_acc == 4'b1111) begin
        if (!(bad_acc && STRICT)) begin
          bcd_n   = dig_acc;
          fv_n    = 1'b1;
          state_n = LOCK;
        end
        seen_n = '0;
        bad_n  = 1'b0;
        cnt_n  = '0;
      end else if (cnt == CNT_LAST) begin
        to_n    = 1'b1;
        seen_n  = '0;
        bad_n   = 1'b0;
        cnt_n   = '0;
        state_n = ACQ;
      end else begin
        seen_n = seen_acc;
        bad_n  = bad_acc;
        cnt_n  = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge tic_ms or posedge rst) begin
    if (rst) begin
      state       <= OFF;
      sseg_q      <= 8'hFF;
      an_q        <= 4'hF;
      seen        <= '0;
      bad         <= 1'b0;
      cnt         <= '0;
      digits      <= '0;
      bcd_out     <= '0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      sseg_q      <= sseg;
      an_q        <= an;
      seen        <= seen_n;
      bad         <= bad_n;
      cnt         <= cnt_n;
      digits      <= digits_n;
      bcd_out     <= bcd_n;
      frame_valid <= fv_n;
      pattern_err <= pe_n;
      anode_err   <= ae_n;
      timeout     <= to_n;
    end
  end

  assign locked = (state == LOCK);

endmodule
